mf_disp_fb_pal_pipe: RTL and testbench
======================================

MF_DISP_FB_PAL_PIPE -- requirements
Module: mf_disp_fb_pal_pipe

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
  WORD_W  32  framebuffer word width; power of two, 8..64
  ADDR_W  16  pixel address width
  COLOR_W  6  bits per colour channel
  PAL_AW  8  palette address width, 1..8
REQ-002 SHALL have ports, one per line: name  direction  width  meaning:
  pix_clk  in  1  sole clock
  resetn  in  1  asynchronous active-low reset
  frame_start  in  1  one-cycle frame boundary pulse
  swap_req  in  1  double-buffer swap request pulse
  bpp_mode  in  2  0=1bpp, 1=2bpp, 2=4bpp, 3=8bpp
  pix_rd_vld  in  1  pixel request
  pix_rd_addr  in  ADDR_W  pixel index
  fb_rd_en  out  1  framebuffer read enable
  fb_rd_addr  out  ADDR_W+1  {buffer select, word address}
  fb_rd_data  in  WORD_W  read data, valid 1 cycle after fb_rd_en
  pal_wr_vld  in  1  palette write
  pal_wr_addr  in  PAL_AW  palette entry
  pal_wr_data  in  3*COLOR_W  {r,g,b}
  fb_sel  out  1  buffer currently displayed
  swap_ack  out  1  one-cycle pulse, swap applied
  pix_out_vld  out  1  RGB valid
  pix_out_r/g/b  out  COLOR_W each  pixel colour
REQ-003 SHALL use one clock, pix_clk; reset resetn SHALL be asynchronous, active-low.

Function
REQ-004 Active mode SHALL be bpp_mode sampled on frame_start only; mid-frame changes ignored.
REQ-005 Pixels per word P = WORD_W/bpp; word address = pix_rd_addr >> log2(P), zero-extended; sub-index = pix_rd_addr mod P.
REQ-006 Request at cycle N: fb_rd_en=1 and fb_rd_addr={~fb_sel, word addr} at N+1 (display reads the buffer not being written).
REQ-007 Cycle N+2: index = fb_rd_data bits [sub*bpp +: bpp], sub-index 0 at LSB; palette read at N+2; pix_out_vld=1 with RGB at N+3. Fixed latency 3, one pixel per cycle, no stalls.
REQ-008 Index width: bpp<PAL_AW zero-extended; bpp>PAL_AW truncated to low PAL_AW bits.
REQ-009 Mode, sub-index and buffer select SHALL travel with each request; frame_start/swap mid-pipeline SHALL NOT alter in-flight pixels.
REQ-010 Palette SHALL be 2^PAL_AW x 3*COLOR_W internal RAM; same-cycle write/read of one address returns old data.
REQ-011 swap_req sets pending; on frame_start with pending (including swap_req in the same cycle) fb_sel toggles next cycle, pending clears, swap_ack pulses that same cycle.
REQ-012 swap_req while pending SHALL be absorbed (one swap only); frame_start without pending: no toggle, no ack.
REQ-013 Requests in the frame_start cycle SHALL use pre-boundary fb_sel and mode.
REQ-014 pix_out_vld low: RGB outputs hold last value; fb_rd_en low: fb_rd_addr holds.

Reset
REQ-015 resetn low SHALL clear fb_sel, swap_ack, pending, fb_rd_en, fb_rd_addr, pix_out_vld, RGB to 0, active mode to 8bpp, and flush the pipeline; palette contents undefined.
REQ-016 Requests in flight at reset assertion SHALL be discarded; no pix_out_vld after release for them.

Configuration
REQ-017 Macro MF_DISP_PAL_BYPASS_EN defined: input pal_bypass (1 bit), sampled on frame_start; when set and mode 8bpp, RGB SHALL be index RGB332 expanded by MSB-first bit replication to COLOR_W, same latency, palette unused.
REQ-018 Macro undefined: pal_bypass port absent; palette always used.

Verification
REQ-019 8bpp, palette[0x5A]=0x3F000, word 0 = 0x00005A00, request addr 1 at cycle 0 -> fb_rd_addr=0x10000 cycle 1, pix_out_vld cycle 3, r=0x3F g=0 b=0.
REQ-020 1bpp, word 0 = 0x80000000, requests 0..31 back-to-back -> 31 outputs palette[0], addr 31 palette[1], continuous vld.
REQ-021 swap_req cycle 10, frame_start cycle 20 -> fb_sel 0->1 and swap_ack at cycle 21; second swap_req cycle 12 -> no extra toggle.
REQ-022 bpp_mode 3->1 at cycle 5, frame_start cycle 9, requests cycles 8-10 -> cycle 8/9 requests decoded 8bpp, cycle 10 decoded 2bpp.
REQ-023 resetn low at cycle 1 with 3 requests in flight -> all outputs 0, no pix_out_vld after release; with MF_DISP_PAL_BYPASS_EN, index 0xE0 bypass -> r=0x3F g=0 b=0.

Source files
------------

// File: rtl/mf_disp_fb_pal_pipe.sv
// Framebuffer-to-RGB pixel pipeline: double-buffered word fetch, index extract, palette lookup.
// Optional RGB332 palette bypass in 8bpp mode when MF_DISP_PAL_BYPASS_EN is defined.
module mf_disp_fb_pal_pipe #(
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned COLOR_W = 6,
  parameter int unsigned PAL_AW  = 8
) (
  input  logic                   pix_clk,
  input  logic                   resetn,
  input  logic                   frame_start,
  input  logic                   swap_req,
  input  logic [1:0]             bpp_mode,
`ifdef MF_DISP_PAL_BYPASS_EN
  input  logic                   pal_bypass,
`endif
  input  logic                   pix_rd_vld,
  input  logic [ADDR_W-1:0]      pix_rd_addr,
  output logic                   fb_rd_en,
  output logic [ADDR_W:0]        fb_rd_addr,
  input  logic [WORD_W-1:0]      fb_rd_data,
  input  logic                   pal_wr_vld,
  input  logic [PAL_AW-1:0]      pal_wr_addr,
  input  logic [3*COLOR_W-1:0]   pal_wr_data,
  output logic                   fb_sel,
  output logic                   swap_ack,
  output logic                   pix_out_vld,
  output logic [COLOR_W-1:0]     pix_out_r,
  output logic [COLOR_W-1:0]     pix_out_g,
  output logic [COLOR_W-1:0]     pix_out_b
);

  localparam int unsigned SubW     = $clog2(WORD_W);
  localparam int unsigned RgbW     = 3 * COLOR_W;
  localparam int unsigned PalDepth = 1 << PAL_AW;

  logic [1:0]      mode_q;
  logic            pending_q, pending_d;
  logic            swap_now;
  logic [1:0]      s1_mode_q, s2_mode_q;
  logic [SubW-1:0] s1_sub_q, s2_sub_q;
  logic            s2_vld_q;

  logic [ADDR_W-1:0] word_addr;
  logic [SubW-1:0]   sub_idx;
  int unsigned       shamt;
  logic [SubW-1:0]   bit_off;
  logic [7:0]        idx_mask, idx8;
  logic [PAL_AW-1:0] pal_idx;
  logic [RgbW-1:0]   rgb_d;

  logic [RgbW-1:0] pal_mem [PalDepth];

  // Bit replication MSB-first to fill a colour channel.
  function automatic logic [COLOR_W-1:0] rep3(input logic [2:0] v);
    logic [COLOR_W-1:0] res;
    for (int i = 0; i < int'(COLOR_W); i++) res[COLOR_W-1-i] = v[2-(i%3)];
    return res;
  endfunction

  function automatic logic [COLOR_W-1:0] rep2(input logic [1:0] v);
    logic [COLOR_W-1:0] res;
    for (int i = 0; i < int'(COLOR_W); i++) res[COLOR_W-1-i] = v[1-(i%2)];
    return res;
  endfunction

  // Swap is taken only at a frame boundary; a same-cycle request counts as pending.
  always_comb begin
    swap_now  = frame_start && (pending_q || swap_req);
    pending_d = pending_q;
    if (swap_now)      pending_d = 1'b0;
    else if (swap_req) pending_d = 1'b1;
  end

  always_comb begin
    shamt     = SubW - 32'(mode_q);
    word_addr = ADDR_W'(pix_rd_addr >> shamt);
    sub_idx   = SubW'(pix_rd_addr) & SubW'((WORD_W >> mode_q) - 32'd1);
  end

  always_comb begin
    unique case (s2_mode_q)
      2'd0:    idx_mask = 8'h01;
      2'd1:    idx_mask = 8'h03;
      2'd2:    idx_mask = 8'h0F;
      default: idx_mask = 8'hFF;
    endcase
    bit_off = s2_sub_q << s2_mode_q;
    idx8    = 8'(fb_rd_data >> bit_off) & idx_mask;
    pal_idx = idx8[PAL_AW-1:0];
  end

`ifdef MF_DISP_PAL_BYPASS_EN
  logic byp_q, s1_byp_q, s2_byp_q;

  always_ff @(posedge pix_clk or negedge resetn) begin
    if (!resetn) begin
      byp_q    <= 1'b0;
      s1_byp_q <= 1'b0;
      s2_byp_q <= 1'b0;
    end else begin
      if (frame_start) byp_q <= pal_bypass;
      if (pix_rd_vld)  s1_byp_q <= byp_q;
      s2_byp_q <= s1_byp_q;
    end
  end

  always_comb begin
    rgb_d = pal_mem[pal_idx];
    if (s2_byp_q && (s2_mode_q == 2'd3)) begin
      rgb_d = {rep3(idx8[7:5]), rep3(idx8[4:2]), rep2(idx8[1:0])};
    end
  end
`else
  always_comb begin
    rgb_d = pal_mem[pal_idx];
  end
`endif

  // Palette RAM: no reset; a read at the write address sees the previous contents.
  always_ff @(posedge pix_clk) begin
    if (pal_wr_vld) pal_mem[pal_wr_addr] <= pal_wr_data;
  end

  always_ff @(posedge pix_clk or negedge resetn) begin
    if (!resetn) begin
      mode_q      <= 2'd3;
      pending_q   <= 1'b0;
      fb_sel      <= 1'b0;
      swap_ack    <= 1'b0;
      fb_rd_en    <= 1'b0;
      fb_rd_addr  <= '0;
      s1_mode_q   <= 2'd3;
      s1_sub_q    <= '0;
      s2_vld_q    <= 1'b0;
      s2_mode_q   <= 2'd3;
      s2_sub_q    <= '0;
      pix_out_vld <= 1'b0;
      pix_out_r   <= '0;
      pix_out_g   <= '0;
      pix_out_b   <= '0;
    end else begin
      if (frame_start) mode_q <= bpp_mode;
      pending_q <= pending_d;
      fb_sel    <= fb_sel ^ swap_now;
      swap_ack  <= swap_now;
      fb_rd_en  <= pix_rd_vld;
      if (pix_rd_vld) begin
        fb_rd_addr <= {~fb_sel, word_addr};
        s1_mode_q  <= mode_q;
        s1_sub_q   <= sub_idx;
      end
      s2_vld_q  <= fb_rd_en;
      s2_mode_q <= s1_mode_q;
      s2_sub_q  <= s1_sub_q;
      pix_out_vld <= s2_vld_q;
      if (s2_vld_q) {pix_out_r, pix_out_g, pix_out_b} <= rgb_d;
    end
  end

endmodule

// File: tb/tb_mf_disp_fb_pal_pipe.sv
// Directed self-checking bench for mf_disp_fb_pal_pipe with a registered framebuffer model.
module tb_mf_disp_fb_pal_pipe;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned COLOR_W = 6;
  localparam int unsigned PAL_AW  = 8;

  logic                 pix_clk = 1'b0;
  logic                 resetn = 1'b0;
  logic                 frame_start = 1'b0;
  logic                 swap_req = 1'b0;
  logic [1:0]           bpp_mode = 2'd3;
  logic                 pix_rd_vld = 1'b0;
  logic [ADDR_W-1:0]    pix_rd_addr = '0;
  logic                 fb_rd_en;
  logic [ADDR_W:0]      fb_rd_addr;
  logic [WORD_W-1:0]    fb_rd_data;
  logic                 pal_wr_vld = 1'b0;
  logic [PAL_AW-1:0]    pal_wr_addr = '0;
  logic [3*COLOR_W-1:0] pal_wr_data = '0;
  logic                 fb_sel;
  logic                 swap_ack;
  logic                 pix_out_vld;
  logic [COLOR_W-1:0]   pix_out_r, pix_out_g, pix_out_b;
`ifdef MF_DISP_PAL_BYPASS_EN
  logic                 pal_bypass = 1'b0;
`endif

  logic [17:0] rgb;
  assign rgb = {pix_out_r, pix_out_g, pix_out_b};

  int compared = 0;
  int mismatched = 0;

  logic [WORD_W-1:0] fbmem [0:31];

  mf_disp_fb_pal_pipe #(
    .WORD_W (WORD_W),
    .ADDR_W (ADDR_W),
    .COLOR_W(COLOR_W),
    .PAL_AW (PAL_AW)
  ) dut (
    .pix_clk    (pix_clk),
    .resetn     (resetn),
    .frame_start(frame_start),
    .swap_req   (swap_req),
    .bpp_mode   (bpp_mode),
`ifdef MF_DISP_PAL_BYPASS_EN
    .pal_bypass (pal_bypass),
`endif
    .pix_rd_vld (pix_rd_vld),
    .pix_rd_addr(pix_rd_addr),
    .fb_rd_en   (fb_rd_en),
    .fb_rd_addr (fb_rd_addr),
    .fb_rd_data (fb_rd_data),
    .pal_wr_vld (pal_wr_vld),
    .pal_wr_addr(pal_wr_addr),
    .pal_wr_data(pal_wr_data),
    .fb_sel     (fb_sel),
    .swap_ack   (swap_ack),
    .pix_out_vld(pix_out_vld),
    .pix_out_r  (pix_out_r),
    .pix_out_g  (pix_out_g),
    .pix_out_b  (pix_out_b)
  );

  always #5 pix_clk = ~pix_clk;

  // Synchronous framebuffer: data valid the cycle after fb_rd_en.
  always @(posedge pix_clk) begin
    if (fb_rd_en) fb_rd_data <= fbmem[{fb_rd_addr[ADDR_W], fb_rd_addr[3:0]}];
  end

  task automatic pal_write(input logic [7:0] a, input logic [17:0] d);
    pal_wr_vld  = 1'b1;
    pal_wr_addr = a;
    pal_wr_data = d;
    @(negedge pix_clk);
    pal_wr_vld = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge pix_clk);
    compared++;
    if ({fb_sel, swap_ack, fb_rd_en, pix_out_vld} !== 4'b0) begin
      mismatched++;
      $display("FAIL reset_flags: got %b expected 0000", {fb_sel, swap_ack, fb_rd_en, pix_out_vld});
    end
    compared++;
    if ({fb_rd_addr, rgb} !== 35'h0) begin
      mismatched++;
      $display("FAIL reset_data: got addr %h rgb %h expected 0", fb_rd_addr, rgb);
    end
    resetn = 1'b1;
    @(negedge pix_clk);
    compared++;
    if ({fb_sel, fb_rd_en, pix_out_vld} !== 3'b0) begin
      mismatched++;
      $display("FAIL post_reset_idle: got %b expected 000", {fb_sel, fb_rd_en, pix_out_vld});
    end
  endtask

  task automatic test_8bpp();
    fbmem[16] = 32'h0000_5A00;
    pal_write(8'h5A, 18'h3F000);
    for (int rnd = 0; rnd < 3; rnd++) begin
      pix_rd_vld = 1'b1; pix_rd_addr = 16'd1;
      @(negedge pix_clk);
      pix_rd_vld = 1'b0;
      compared++;
      if (fb_rd_en !== 1'b1 || fb_rd_addr !== 17'h10000) begin
        mismatched++;
        $display("FAIL 8bpp_fetch: got en %b addr %h expected 1 10000", fb_rd_en, fb_rd_addr);
      end
      @(negedge pix_clk);
      compared++;
      if (fb_rd_en !== 1'b0 || fb_rd_addr !== 17'h10000 || pix_out_vld !== 1'b0) begin
        mismatched++;
        $display("FAIL 8bpp_addr_hold: got en %b addr %h vld %b expected 0 10000 0",
                 fb_rd_en, fb_rd_addr, pix_out_vld);
      end
      // Second round rewrites the entry in the same cycle it is read.
      if (rnd == 1) begin
        pal_wr_vld = 1'b1; pal_wr_addr = 8'h5A; pal_wr_data = 18'h00FC0;
      end
      @(negedge pix_clk);
      pal_wr_vld = 1'b0;
      compared++;
      if (pix_out_vld !== 1'b1 || rgb !== ((rnd == 2) ? 18'h00FC0 : 18'h3F000)) begin
        mismatched++;
        $display("FAIL 8bpp_rgb%0d: got vld %b rgb %h expected 1 %h", rnd, pix_out_vld, rgb,
                 (rnd == 2) ? 18'h00FC0 : 18'h3F000);
      end
      @(negedge pix_clk);
      compared++;
      if (pix_out_vld !== 1'b0 || rgb !== ((rnd == 2) ? 18'h00FC0 : 18'h3F000)) begin
        mismatched++;
        $display("FAIL 8bpp_rgb_hold%0d: got vld %b rgb %h", rnd, pix_out_vld, rgb);
      end
    end
  endtask

  task automatic test_1bpp_back_to_back();
    logic [17:0] exp;
    fbmem[16] = 32'h8000_0000;
    pal_write(8'h00, 18'h01041);
    pal_write(8'h01, 18'h2AAAA);
    bpp_mode = 2'd0; frame_start = 1'b1;
    @(negedge pix_clk);
    frame_start = 1'b0;
    for (int i = 0; i < 35; i++) begin
      if (i >= 3) begin
        exp = (i - 3 == 31) ? 18'h2AAAA : 18'h01041;
        compared++;
        if (pix_out_vld !== 1'b1 || rgb !== exp) begin
          mismatched++;
          $display("FAIL 1bpp_pix%0d: got vld %b rgb %h expected 1 %h", i - 3, pix_out_vld, rgb,
                   exp);
        end
      end
      pix_rd_vld  = (i < 32);
      pix_rd_addr = 16'(i);
      @(negedge pix_clk);
    end
    compared++;
    if (pix_out_vld !== 1'b0) begin
      mismatched++;
      $display("FAIL 1bpp_tail: got vld %b expected 0", pix_out_vld);
    end
  endtask

  task automatic test_swap();
    for (int c = 0; c < 28; c++) begin
      if (c <= 20) begin
        compared++;
        if (fb_sel !== 1'b0 || swap_ack !== 1'b0) begin
          mismatched++;
          $display("FAIL swap_pre%0d: got sel %b ack %b expected 0 0", c, fb_sel, swap_ack);
        end
      end else if (c == 21) begin
        compared++;
        if (fb_sel !== 1'b1 || swap_ack !== 1'b1 || fb_rd_en !== 1'b1 ||
            fb_rd_addr !== 17'h10000) begin
          mismatched++;
          $display("FAIL swap_apply: got sel %b ack %b en %b addr %h expected 1 1 1 10000",
                   fb_sel, swap_ack, fb_rd_en, fb_rd_addr);
        end
      end else begin
        compared++;
        if (fb_sel !== 1'b1 || swap_ack !== 1'b0) begin
          mismatched++;
          $display("FAIL swap_post%0d: got sel %b ack %b expected 1 0", c, fb_sel, swap_ack);
        end
      end
      if (c == 23) begin
        compared++;
        if (pix_out_vld !== 1'b1 || rgb !== 18'h01041) begin
          mismatched++;
          $display("FAIL swap_inflight: got vld %b rgb %h expected 1 01041", pix_out_vld, rgb);
        end
      end
      swap_req    = (c == 10 || c == 12);
      frame_start = (c == 20 || c == 25);
      pix_rd_vld  = (c == 20);
      pix_rd_addr = '0;
      @(negedge pix_clk);
    end
    swap_req = 1'b0; frame_start = 1'b0; pix_rd_vld = 1'b0;
  endtask

  task automatic test_mode_change();
    fbmem[0] = 32'h0000_04C6;
    fbmem[1] = 32'h0000_0007;
    pal_write(8'hC6, 18'h3F03F);
    pal_write(8'h07, 18'h00FFF);
    pal_write(8'h01, 18'h15555);
    bpp_mode = 2'd3; frame_start = 1'b1;
    @(negedge pix_clk);
    frame_start = 1'b0;
    for (int c = 0; c < 15; c++) begin
      if (c == 9 || c == 10 || c == 11) begin
        compared++;
        if (fb_rd_en !== 1'b1 || fb_rd_addr !== ((c == 10) ? 17'h00001 : 17'h00000)) begin
          mismatched++;
          $display("FAIL mode_fetch%0d: got en %b addr %h expected 1 %h", c, fb_rd_en,
                   fb_rd_addr, (c == 10) ? 17'h00001 : 17'h00000);
        end
      end
      if (c == 11 || c == 12 || c == 13) begin
        compared++;
        if (pix_out_vld !== 1'b1 ||
            rgb !== ((c == 11) ? 18'h3F03F : (c == 12) ? 18'h00FFF : 18'h15555)) begin
          mismatched++;
          $display("FAIL mode_rgb%0d: got vld %b rgb %h", c, pix_out_vld, rgb);
        end
      end
      bpp_mode    = (c >= 5) ? 2'd1 : 2'd3;
      frame_start = (c == 9);
      pix_rd_vld  = (c >= 8 && c <= 10);
      pix_rd_addr = (c == 8) ? 16'd0 : (c == 9) ? 16'd4 : 16'd5;
      @(negedge pix_clk);
    end
    frame_start = 1'b0; pix_rd_vld = 1'b0;
    compared++;
    if (fb_sel !== 1'b1 || swap_ack !== 1'b0) begin
      mismatched++;
      $display("FAIL mode_no_swap: got sel %b ack %b expected 1 0", fb_sel, swap_ack);
    end
  endtask

  task automatic test_reset_flush();
    swap_req = 1'b1; pix_rd_vld = 1'b1; pix_rd_addr = '0;
    @(negedge pix_clk);
    swap_req = 1'b0;
    @(negedge pix_clk);
    #2 resetn = 1'b0;
    #1;
    compared++;
    if ({fb_sel, swap_ack, fb_rd_en, pix_out_vld, fb_rd_addr, rgb} !== 39'h0) begin
      mismatched++;
      $display("FAIL flush_async: got sel %b ack %b en %b vld %b addr %h rgb %h expected all 0",
               fb_sel, swap_ack, fb_rd_en, pix_out_vld, fb_rd_addr, rgb);
    end
    pix_rd_vld = 1'b0;
    repeat (2) @(negedge pix_clk);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge pix_clk);
      compared++;
      if (pix_out_vld !== 1'b0) begin
        mismatched++;
        $display("FAIL flush_ghost%0d: got vld %b expected 0", i, pix_out_vld);
      end
    end
    pix_rd_vld = 1'b1; pix_rd_addr = 16'd4;
    @(negedge pix_clk);
    pix_rd_vld = 1'b0;
    compared++;
    if (fb_rd_en !== 1'b1 || fb_rd_addr !== 17'h10001) begin
      mismatched++;
      $display("FAIL flush_mode8: got en %b addr %h expected 1 10001", fb_rd_en, fb_rd_addr);
    end
    frame_start = 1'b1; bpp_mode = 2'd3;
    @(negedge pix_clk);
    frame_start = 1'b0;
    compared++;
    if (swap_ack !== 1'b0 || fb_sel !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_pending: got ack %b sel %b expected 0 0", swap_ack, fb_sel);
    end
  endtask

`ifdef MF_DISP_PAL_BYPASS_EN
  task automatic test_bypass();
    fbmem[17] = 32'h0000_00E0;
    pal_bypass = 1'b1; bpp_mode = 2'd3; frame_start = 1'b1;
    @(negedge pix_clk);
    frame_start = 1'b0;
    pix_rd_vld = 1'b1; pix_rd_addr = 16'd4;
    @(negedge pix_clk);
    pix_rd_vld = 1'b0;
    repeat (2) @(negedge pix_clk);
    compared++;
    if (pix_out_vld !== 1'b1 || rgb !== 18'h3F000) begin
      mismatched++;
      $display("FAIL bypass_rgb: got vld %b rgb %h expected 1 3F000", pix_out_vld, rgb);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < 32; i++) fbmem[i] = '0;
    test_reset();
    test_8bpp();
    test_1bpp_back_to_back();
    test_swap();
    test_mode_change();
    test_reset_flush();
`ifdef MF_DISP_PAL_BYPASS_EN
    test_bypass();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
